// File: rtl/riscv_pkg.sv
// Shared RISC-V memory-stage definitions: funct3 width codes, LSU state
// encoding and the access legality check used at request acceptance.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    // Unsigned widths have no store form, and H/W must be naturally aligned.
    function automatic logic lsu_fault(input logic [2:0] f3, input logic we,
                                       input logic [1:0] lane);
        logic flt;
        case (f3)
            F3_B:    flt = 1'b0;
            F3_H:    flt = lane[0];
            F3_W:    flt = (lane != 2'b00);
            F3_BU:   flt = we;
            F3_HU:   flt = we | lane[0];
            default: flt = 1'b1;
        endcase
        return flt;
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane steering for the load/store unit: merges store data into the
// addressed word and extracts/extends load data from it.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  lane_i,
    output logic [31:0] new_word_o,
    output logic [31:0] load_data_o
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign sel_byte = old_word_i[{lane_i, 3'b000} +: 8];
    assign sel_half = lane_i[1] ? old_word_i[31:16] : old_word_i[15:0];

    always_comb begin
        new_word_o = old_word_i;
        case (funct3_i)
            F3_B:    new_word_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
            F3_H:    new_word_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            F3_W:    new_word_o = wdata_i;
            default: new_word_o = old_word_i;
        endcase
    end

    always_comb begin
        load_data_o = 32'h0;
        case (funct3_i)
            F3_B:    load_data_o = {{24{sel_byte[7]}}, sel_byte};
            F3_H:    load_data_o = {{16{sel_half[15]}}, sel_half};
            F3_W:    load_data_o = old_word_i;
            F3_BU:   load_data_o = {24'h0, sel_byte};
            F3_HU:   load_data_o = {16'h0, sel_half};
            default: load_data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: RISC-V B/H/W loads and stores against an internal word
// memory behind a valid/ready request and a one-cycle response pulse.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        resp_valid,
    output logic        access_fault
);

    localparam int AW = $clog2(DEPTH_WORDS);

    lsu_state_e     state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           fault_q, fault_d;

    logic           we_q;
    logic [2:0]     f3_q;
    logic [AW+1:0]  addr_q;
    logic [31:0]    wdata_q;

    logic [31:0]    mem [DEPTH_WORDS];

    logic           accept;
    logic           req_fault;
    logic           commit;
    logic           eff_we;
    logic [2:0]     eff_f3;
    logic [AW+1:0]  eff_addr;
    logic [31:0]    eff_wdata;
    logic [AW-1:0]  word_idx;
    logic [31:0]    old_word;
    logic [31:0]    new_word;
    logic [31:0]    load_data;
    logic           unused_addr_hi;

    assign req_ready    = (state_q == ST_IDLE);
    assign accept       = req_valid && req_ready;
    assign req_fault    = lsu_fault(funct3, mem_write, addr[1:0]);
    assign unused_addr_hi = ^addr[31:AW+2];

    // With no wait states the commit lands on the acceptance edge, so the
    // datapath must see the live request rather than the latched copy.
    assign eff_we    = req_ready ? mem_write     : we_q;
    assign eff_f3    = req_ready ? funct3        : f3_q;
    assign eff_addr  = req_ready ? addr[AW+1:0]  : addr_q;
    assign eff_wdata = req_ready ? wdata         : wdata_q;
    assign word_idx  = eff_addr[AW+1:2];
    assign old_word  = mem[word_idx];

    lsu_align u_align (
        .old_word_i  (old_word),
        .wdata_i     (eff_wdata),
        .funct3_i    (eff_f3),
        .lane_i      (eff_addr[1:0]),
        .new_word_o  (new_word),
        .load_data_o (load_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_fault) begin
                        state_d = ST_RESP;
                        rdata_d = 32'h0;
                        fault_d = 1'b1;
                    end else if (WAIT_STATES == 0) begin
                        commit  = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'(WAIT_STATES)) begin
                    commit  = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        if (commit) begin
            rdata_d = eff_we ? 32'h0 : load_data;
            fault_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= mem_write;
            f3_q    <= funct3;
            addr_q  <= addr[AW+1:0];
            wdata_q <= wdata;
        end
    end

    // rst gates the write so a reset arriving before the commit edge aborts it.
    always_ff @(posedge clk) begin
        if (commit && eff_we && !rst)
            mem[word_idx] <= new_word;
    end

    assign resp_valid   = (state_q == ST_RESP);
    assign rdata        = rdata_q;
    assign access_fault = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (WAIT_STATES=2, DEPTH_WORDS=256).
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        resp_valid;
    logic        access_fault;

    int total = 0;
    int bad   = 0;

    load_store_unit #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .mem_write    (mem_write),
        .funct3       (funct3),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .resp_valid   (resp_valid),
        .access_fault (access_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_flt;
        int          exp_lat;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Issues one request and checks latency, response values, one-cycle pulse
    // and that rdata/access_fault hold afterwards.
    task automatic access(input string nm, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_flt,
                          input int exp_lat);
        int  n;
        bit  got;
        @(negedge clk);
        chk({nm, ".ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        mem_write = we;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        mem_write = ~we;
        funct3    = 3'b111;
        addr      = 32'hFFFF_FFFF;
        wdata     = 32'h5A5A_5A5A;
        n   = 0;
        got = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1 && exp_lat > 1)
                chk({nm, ".ready_busy"}, 32'(req_ready), 32'd0);
            if (resp_valid) begin
                n   = i;
                got = 1'b1;
                break;
            end
        end
        chk({nm, ".latency"}, 32'(n), 32'(exp_lat));
        if (got) begin
            chk({nm, ".rdata"}, rdata, exp_rd);
            chk({nm, ".fault"}, 32'(access_fault), 32'(exp_flt));
            @(negedge clk);
            chk({nm, ".pulse_end"}, 32'(resp_valid), 32'd0);
            chk({nm, ".rdata_hold"}, rdata, exp_rd);
            chk({nm, ".fault_hold"}, 32'(access_fault), 32'(exp_flt));
        end
    endtask

    initial begin
        int seen;

        // Shared memory state flows from one vector to the next.
        vt.push_back('{"sw_10",    1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 3});
        vt.push_back('{"lw_10",    1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 3});
        vt.push_back('{"sb_13",    1'b1, 3'b000, 32'h13,  32'h00000080, 32'h0,        1'b0, 3});
        vt.push_back('{"lb_13",    1'b0, 3'b000, 32'h13,  32'h0,        32'hFFFFFF80, 1'b0, 3});
        vt.push_back('{"lbu_13",   1'b0, 3'b100, 32'h13,  32'h0,        32'h00000080, 1'b0, 3});
        vt.push_back('{"lw_10b",   1'b0, 3'b010, 32'h10,  32'h0,        32'h80ADBEEF, 1'b0, 3});
        vt.push_back('{"sw_10r",   1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 3});
        vt.push_back('{"sh_12",    1'b1, 3'b001, 32'h12,  32'h00008001, 32'h0,        1'b0, 3});
        vt.push_back('{"lh_12",    1'b0, 3'b001, 32'h12,  32'h0,        32'hFFFF8001, 1'b0, 3});
        vt.push_back('{"lhu_12",   1'b0, 3'b101, 32'h12,  32'h0,        32'h00008001, 1'b0, 3});
        vt.push_back('{"lw_10c",   1'b0, 3'b010, 32'h10,  32'h0,        32'h8001BEEF, 1'b0, 3});
        vt.push_back('{"lb_10",    1'b0, 3'b000, 32'h10,  32'h0,        32'hFFFFFFEF, 1'b0, 3});
        vt.push_back('{"lh_10",    1'b0, 3'b001, 32'h10,  32'h0,        32'hFFFFBEEF, 1'b0, 3});
        vt.push_back('{"lbu_11",   1'b0, 3'b100, 32'h11,  32'h0,        32'h000000BE, 1'b0, 3});
        vt.push_back('{"lw_11f",   1'b0, 3'b010, 32'h11,  32'h0,        32'h0,        1'b1, 1});
        vt.push_back('{"sh_13f",   1'b1, 3'b001, 32'h13,  32'h0000FFFF, 32'h0,        1'b1, 1});
        vt.push_back('{"lw_10d",   1'b0, 3'b010, 32'h10,  32'h0,        32'h8001BEEF, 1'b0, 3});
        vt.push_back('{"f3_011f",  1'b0, 3'b011, 32'h10,  32'h0,        32'h0,        1'b1, 1});
        vt.push_back('{"sbu_f",    1'b1, 3'b100, 32'h10,  32'h000000AA, 32'h0,        1'b1, 1});
        vt.push_back('{"lh_11f",   1'b0, 3'b001, 32'h11,  32'h0,        32'h0,        1'b1, 1});
        vt.push_back('{"lw_10e",   1'b0, 3'b010, 32'h10,  32'h0,        32'h8001BEEF, 1'b0, 3});
        vt.push_back('{"sw_400",   1'b1, 3'b010, 32'h400, 32'h11111111, 32'h0,        1'b0, 3});
        vt.push_back('{"lw_000",   1'b0, 3'b010, 32'h0,   32'h0,        32'h11111111, 1'b0, 3});
        vt.push_back('{"sw_20z",   1'b1, 3'b010, 32'h20,  32'h00000000, 32'h0,        1'b0, 3});
        vt.push_back('{"lw_000b",  1'b0, 3'b010, 32'h0,   32'h0,        32'h11111111, 1'b0, 3});

        // Reset state
        #12;
        chk("rst.ready", 32'(req_ready), 32'd1);
        chk("rst.resp_valid", 32'(resp_valid), 32'd0);
        chk("rst.fault", 32'(access_fault), 32'd0);
        chk("rst.rdata", rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vt[i])
            access(vt[i].nm, vt[i].we, vt[i].f3, vt[i].a, vt[i].wd,
                   vt[i].exp_rd, vt[i].exp_flt, vt[i].exp_lat);

        // Reset during the first WAIT cycle aborts the store.
        @(negedge clk);
        req_valid = 1'b1;
        mem_write = 1'b1;
        funct3    = 3'b010;
        addr      = 32'h20;
        wdata     = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("abort.busy", 32'(req_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("abort.ready_in_rst", 32'(req_ready), 32'd1);
        chk("abort.resp_in_rst", 32'(resp_valid), 32'd0);
        chk("abort.rdata_in_rst", rdata, 32'h0);
        chk("abort.fault_in_rst", 32'(access_fault), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("abort.no_resp", 32'(seen), 32'd0);
        chk("abort.ready_after", 32'(req_ready), 32'd1);
        access("abort.lw_20", 1'b0, 3'b010, 32'h20, 32'h0, 32'h00000000, 1'b0, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
